// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan display.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Packed so that SEG_GLYPHS[n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder with blank override.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = blank_i ? SEG_BLANK : SEG_GLYPHS[hex_i];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed display: decimal on digits 1:0, separator dp on
// digit 2, hex on digit 3, with a stability-filtered per-frame value latch.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value_in,
    input  logic       blank_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [3:0]    s1_q, s2_q;
    logic [3:0]    disp_q, disp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q;
    logic          dp_q, dp_d;

    logic          tick;
    logic          stable;
    logic          tens_nz;
    logic [3:0]    units;
    logic [3:0]    nib;
    logic          nib_blank;
    logic [6:0]    dec_seg;

    assign tick   = (cnt_q == CW'(REFRESH_DIV - 1));
    assign stable = (s1_q == s2_q);

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        disp_d = disp_q;
        // Only the 3->0 wrap may refresh the value, so a frame never mixes values.
        if (tick && (idx_q == 2'd3) && stable) begin
            disp_d = s2_q;
        end
    end

    always_comb begin
        tens_nz = (disp_q >= 4'd10);
        units   = tens_nz ? disp_q - 4'd10 : disp_q;
    end

    always_comb begin
        nib       = disp_q;
        nib_blank = 1'b0;
        unique case (idx_q)
            2'd0: nib = units;
            2'd1: begin
                nib       = 4'd1;
                nib_blank = !tens_nz;
            end
            2'd2: nib_blank = 1'b1;
            2'd3: nib = disp_q;
        endcase
    end

    seg7_decoder u_decoder (
        .hex_i   (nib),
        .blank_i (nib_blank),
        .seg_o   (dec_seg)
    );

    always_comb begin
        an_d = blank_in ? '1 : ~(4'b0001 << idx_q);
        dp_d = (idx_q != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            disp_q <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            s1_q   <= value_in;
            s2_q   <= s1_q;
            disp_q <= disp_d;
            an_q   <= an_d;
            seg_q  <= dec_seg;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

- Downstream consumer of the divided-clock 4-bit counter on the 100 MHz board.
- Samples the counter value, filters it for stability, and drives a 4-digit common-anode seven-segment display by time multiplexing.
- Digits 1:0 show the value in decimal with leading-zero blanking; digit 3 shows it in hex; digit 2 is blank with the decimal point lit as a separator.

## Interface
- REFRESH_DIV, default 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Benches use 4. Legal range 2..2^20.
- clk  in  1  100 MHz system clock.
- rst  in  1  reset; synchronous, active-high.
- value_in  in  4  counter value from the divided-clock domain; treated as asynchronous.
- blank_in  in  1  1 = all anodes off; scanning continues.
- an  out  4  anode enables, active-low; an[0] = rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- **Prescaler**
  - cnt counts 0..REFRESH_DIV-1, wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
- **Digit index** idx (2 bit): advances 0→1→2→3→0 on tick.
- **Input capture**
  - s1 <= value_in and s2 <= s1, every clk.
  - The pair is stable when s1 == s2.
- **Frame latch** disp_val (4 bit)
  - Loads s2 on the tick where idx wraps 3→0, only if stable.
  - If not stable, holds its old value for the whole next frame.
  - All four digits of a frame therefore show the same value.
- **Digit content** (d = disp_val)
  - idx 0: units digit, d mod 10.
  - idx 1: tens digit, 1 if d ≥ 10, otherwise blank (leading-zero blanking).
  - idx 2: segments blank, dp = 0.
  - idx 3: hex of d, glyphs 0-9, A, b, C, d, E, F.
  - dp = 1 on every digit except idx 2.
- **Output registers**
  - an, seg and dp are registered every clk from idx, disp_val and blank_in.
  - an is one-hot-low on bit idx, or 4'b1111 when blank_in = 1.
  - seg and dp follow idx normally while blanked.
- **Glyphs**
  - 0 = 1000000, 1 = 1111001, 3 = 0110000, 5 = 0010010, 7 = 1111000, 9 = 0010000.
  - A = 0001000, b = 0000011, d = 0100001, F = 0001110.
  - blank = 1111111.

## Timing
- **Reset values**: cnt = 0, idx = 0, s1 = s2 = 0, disp_val = 0, an = 4'b1111, seg = 7'b1111111, dp = 1.
- **First edge with rst low**: an = 1110, seg = 1000000 ("0").
- **Latency**: an/seg/dp reflect idx and disp_val one clk later. an and seg change on the same edge, so there is no cross-digit ghosting.
- **Input to display**
  - 2 clk through the synchroniser, then wait for the next 3→0 wrap.
  - Worst case is 4·REFRESH_DIV + 3 clk.
- **Digit slot length**: exactly REFRESH_DIV clk; one frame = 4·REFRESH_DIV clk.
- **Simultaneous rst and tick**: rst wins.
- **rst mid-frame**: all state returns to reset values on that edge; the frame restarts at idx 0.
- **blank_in**
  - Takes effect on an one clk after it changes.
  - On release, the display resumes on the current idx with no frame restart.

## Structure
- **Package seg7_pkg** holds:
  - SEG_BLANK = 7'b1111111.
  - The 16-entry hex glyph table as localparam constants.
  - The digit-index typedef (2 bit).
- **Sub-module seg7_decoder**: combinational, 4-bit hex → 7-bit active-low glyph, with a blank input forcing SEG_BLANK. It is instantiated once on the muxed digit nibble.
- The top holds the prescaler, idx, synchroniser, frame latch, BCD split (compare ≥ 10, subtract 10) and output registers.

## Test plan
All scenarios use REFRESH_DIV = 4.
- **Reset**: hold rst 3 clk → an = 1111, seg = 1111111, dp = 1. First clk after release → an = 1110, seg = 1000000.
- **Two-digit value**: value_in = 13 held ≥ 2 frames → frame shows
  - an 1110: seg 0110000.
  - an 1101: seg 1111001.
  - an 1011: seg 1111111, dp = 0.
  - an 0111: seg 0100001.
- **Leading-zero blanking**: value_in = 7 → digit1 seg = 1111111; digit0 and digit3 seg = 1111000.
- **Mid-frame change**: value_in changes 5 → 9 while idx = 1 → remaining digits of that frame still show 5. The next frame shows 9 on digit0 and digit3.
- **Unstable input**: value_in toggles 3/12 every clk across the wrap tick → disp_val holds its previous value. The stable value is then accepted at the following wrap.
- **Blanking and reset**
  - blank_in = 1 for 6 clk → an = 1111 throughout while idx keeps advancing.
  - On release, an matches the predicted idx.
  - rst asserted at idx = 2 → reset values on the next edge.
